tlc_phase_fsm: RTL

- Traffic-light phase sequencer for a two-way intersection (NS/EW) with a pedestrian crossing and night flashing mode.
- Sits directly upstream of the blinker: drives its enable (blink_en) and consumes its square-wave output (blink) to flash both yellow lamps in night mode.
- All phase durations are counted in clk cycles, matching the blinker's tick convention: small values for simulation, ~10^7-10^8 for the board.

---
 rtl/tlc_phase_fsm.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/tlc_phase_fsm.sv
// Traffic-light phase sequencer for a two-way intersection with pedestrian walk and night flashing.
// Optional lamp-fault flash input is enabled by defining TLC_FAULT_FLASH_EN.
module tlc_phase_fsm #(
    parameter int TW           = 16,
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 2,
    parameter int PED_TICKS    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       night_mode,
    input  logic       ped_req,
    input  logic       blink,
`ifdef TLC_FAULT_FLASH_EN
    input  logic       lamp_fault,
`endif
    output logic       blink_en,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       ped_walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        ALL_RED_A = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALL_RED_B = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        PED_WALK  = 3'd6,
        NIGHT     = 3'd7
    } state_t;

    localparam logic [TW-1:0] GREEN_LOAD  = TW'(GREEN_TICKS - 1);
    localparam logic [TW-1:0] YELLOW_LOAD = TW'(YELLOW_TICKS - 1);
    localparam logic [TW-1:0] ALLRED_LOAD = TW'(ALLRED_TICKS - 1);
    localparam logic [TW-1:0] PED_LOAD    = TW'(PED_TICKS - 1);

    state_t          state_reg, state_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic            next_dir_reg, next_dir_next;
    logic            ped_pending_reg, ped_pending_next;
    logic            expired;
    logic            fault_force;

    // Timer value loaded on entry so the phase lasts exactly its duration.
    function automatic logic [TW-1:0] load_for(input state_t s);
        case (s)
            NS_GREEN, EW_GREEN:   load_for = GREEN_LOAD;
            NS_YELLOW, EW_YELLOW: load_for = YELLOW_LOAD;
            ALL_RED_A, ALL_RED_B: load_for = ALLRED_LOAD;
            PED_WALK:             load_for = PED_LOAD;
            default:              load_for = '0;
        endcase
    endfunction

`ifdef TLC_FAULT_FLASH_EN
    assign fault_force = lamp_fault;
`else
    assign fault_force = 1'b0;
`endif

    assign expired = (timer_reg == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ALL_RED_B;
            timer_reg       <= ALLRED_LOAD;
            next_dir_reg    <= 1'b0;
            ped_pending_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            next_dir_reg    <= next_dir_next;
            ped_pending_reg <= ped_pending_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        timer_next       = expired ? '0 : timer_reg - TW'(1);
        next_dir_next    = next_dir_reg;
        ped_pending_next = ped_pending_reg;

        if (ped_req && state_reg != PED_WALK && state_reg != NIGHT)
            ped_pending_next = 1'b1;

        case (state_reg)
            ALL_RED_A, ALL_RED_B: begin
                if (expired) begin
                    if (night_mode)           state_next = NIGHT;
                    else if (ped_pending_reg) state_next = PED_WALK;
                    else if (next_dir_reg)    state_next = EW_GREEN;
                    else                      state_next = NS_GREEN;
                end
            end
            NS_GREEN:  if (expired) state_next = NS_YELLOW;
            NS_YELLOW: if (expired) state_next = ALL_RED_B;
            EW_GREEN:  if (expired) state_next = EW_YELLOW;
            EW_YELLOW: if (expired) state_next = ALL_RED_A;
            PED_WALK:  if (expired) state_next = next_dir_reg ? EW_GREEN : NS_GREEN;
            NIGHT: begin
                timer_next = '0;
                if (!night_mode) state_next = ALL_RED_A;
            end
            default:   state_next = ALL_RED_B;
        endcase

        if (fault_force)
            state_next = NIGHT;

        // Entry actions: reload the timer, steer direction, consume the walk request.
        if (state_next != state_reg) begin
            timer_next = load_for(state_next);
            if (state_next == ALL_RED_B) next_dir_next = 1'b1;
            if (state_next == ALL_RED_A) next_dir_next = 1'b0;
            if (state_next == PED_WALK)  ped_pending_next = 1'b0;
        end
    end

    always_comb begin
        ns_light = 3'b100;
        ew_light = 3'b100;
        ped_walk = 1'b0;
        blink_en = 1'b0;
        phase    = state_reg;
        case (state_reg)
            NS_GREEN:  ns_light = 3'b001;
            NS_YELLOW: ns_light = 3'b010;
            EW_GREEN:  ew_light = 3'b001;
            EW_YELLOW: ew_light = 3'b010;
            PED_WALK:  ped_walk = 1'b1;
            NIGHT: begin
                ns_light = {1'b0, blink, 1'b0};
                ew_light = {1'b0, blink, 1'b0};
                blink_en = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
